// File: rtl/circ_buff_mul_arbiter.sv
// circ_buff_mul_arbiter
//   Several circular-buffer channels share one 8x16 unsigned multiplier to
//   form their address offsets (index x stride). Requests are arbitrated,
//   the winner's operands drive the multiplier, and the 24-bit product is
//   registered together with the winner's ID onto one valid/ready channel.
//
//   Build option: CIRC_BUFF_MUL_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest asserted index wins (no rr_ptr)
//     undefined -> round-robin starting at rr_ptr
//
// Ports
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   req_valid/req_ready     per-requester handshake (NUM_REQ bits)
//   req_a  [NUM_REQ*8-1:0]  operand A per requester, 8 bits each
//   req_b  [NUM_REQ*16-1:0] operand B per requester, 16 bits each
//   res_valid/res_ready     result handshake
//   res_data [23:0]         A x B
//   res_id   [ID_W-1:0]     requester that owns res_data

// Per-requester operand gate: a lane contributes its operands to the shared
// multiplier only when it holds the grant, so the lanes can be OR-combined.
module circ_buff_mul_arbiter_lane (
  input  logic        gnt,
  input  logic [7:0]  a,
  input  logic [15:0] b,
  output logic [7:0]  a_m,
  output logic [15:0] b_m
);
  assign a_m = gnt ? a : '0;
  assign b_m = gnt ? b : '0;
endmodule

module circ_buff_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*8-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [23:0]           res_data,
  output logic [ID_W-1:0]       res_id
);

  logic                       can_accept;
  logic                       found;
  logic                       accept;
  logic [ID_W-1:0]            gnt;
  logic [NUM_REQ-1:0]         gnt_oh;
  logic [NUM_REQ-1:0][7:0]    a_m;
  logic [NUM_REQ-1:0][15:0]   b_m;
  logic [7:0]                 mul_a;
  logic [15:0]                mul_b;
  logic [23:0]                prod;

  // Output register can take a new product if empty or draining this cycle.
  // Holding reset out of the grant keeps requests unaccepted during reset.
  assign can_accept = !ap_rst && (!res_valid || res_ready);

`ifdef CIRC_BUFF_MUL_ARB_FIXED_PRIO_EN
  // Descending scan: the last hit (lowest index) wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found = 1'b1;
        gnt   = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   sum;

  // Scan offsets from the far end toward rr_ptr so the requester closest
  // to rr_ptr (going upward with wrap) is the final, winning assignment.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
  end
`endif

  always_comb begin
    gnt_oh = '0;
    if (found && can_accept)
      gnt_oh[gnt] = 1'b1;
  end

  assign req_ready = gnt_oh;
  assign accept    = |gnt_oh;

  // Shared multiplier: one-hot gated operands OR-combined into a single mux.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    circ_buff_mul_arbiter_lane u_lane (
      .gnt (gnt_oh[i]),
      .a   (req_a[8*i +: 8]),
      .b   (req_b[16*i +: 16]),
      .a_m (a_m[i]),
      .b_m (b_m[i])
    );
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      mul_a = mul_a | a_m[k];
      mul_b = mul_b | b_m[k];
    end
  end

  assign prod = 24'(mul_a) * 24'(mul_b);

  // Single output stage; load and drain may coincide, so no bubble.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= prod;
      res_id    <= gnt;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_circ_buff_mul_arbiter.sv
module tb_circ_buff_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*8-1:0]  req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [23:0]           res_data;
  logic [ID_W-1:0]       res_id;

  circ_buff_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int id;
    int data;
    int stamp;
  } exp_t;

  exp_t               q[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc    = 0;
  logic [NUM_REQ-1:0] acc_last = '0;
  bit                 rst_prev = 1'b0;
  int                 m_ptr  = 0;
  bit                 m_full = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Predictor: from the inputs presented for the coming edge and the
  // model's own notion of the output register, decide the grant, check
  // req_ready, and queue the product that must appear after that edge.
  always @(negedge ap_clk) begin : predictor
    int g;
    int i;
    bit can;
    logic [NUM_REQ-1:0] exp_rdy;
    if (rst_prev) begin
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data",  int'(res_data),  0);
      chk("rst_res_id",    int'(res_id),    0);
    end
    if (ap_rst) begin
      chk("rst_req_ready", int'(req_ready), 0);
      m_ptr    = 0;
      m_full   = 1'b0;
      acc_last = '0;
      q.delete();
    end else begin
      can = !m_full || res_ready;
      g   = -1;
      if (can) begin
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CIRC_BUFF_MUL_ARB_FIXED_PRIO_EN
          i = k;
`else
          i = (m_ptr + k) % NUM_REQ;
`endif
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      acc_last = req_valid & req_ready;
      if (g >= 0) begin
        q.push_back('{id: g,
                      data: int'(req_a[g*8 +: 8]) * int'(req_b[g*16 +: 16]),
                      stamp: cyc + 1});
        m_ptr  = (g + 1) % NUM_REQ;
        m_full = 1'b1;
      end else if (res_ready) begin
        m_full = 1'b0;
      end
    end
    rst_prev = ap_rst;
  end

  // Monitor: whatever the DUT presents must be the oldest due expectation.
  always @(negedge ap_clk) begin : monitor
    if (!ap_rst) begin
      if (res_valid) begin
        if (q.size() == 0 || q[0].stamp > cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id=%0d data=%0d with nothing due",
                   res_id, res_data);
        end else begin
          chk("res_data", int'(res_data), q[0].data);
          chk("res_id",   int'(res_id),   q[0].id);
          if (res_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].stamp <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_result: got res_valid=0 want id=%0d data=%0d",
                 q[0].id, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]       = 1'b1;
    req_a[i*8 +: 8]    = 8'(a);
    req_b[i*16 +: 16]  = 16'(b);
  endtask

  task automatic drop_accepted();
    req_valid = req_valid & ~acc_last;
  endtask

  task automatic fill_all();
    for (int i = 0; i < NUM_REQ; i++)
      if (!req_valid[i]) set_req(i, $urandom_range(0, 255), $urandom_range(0, 65535));
  endtask

  // Let pending requests be served without adding new ones.
  task automatic drain_reqs();
    res_ready = 1'b1;
    for (int n = 0; n < 3*NUM_REQ && req_valid != '0; n++) begin
      step();
      drop_accepted();
    end
    chk("reqs_drained", int'(req_valid), 0);
  endtask

  initial begin : driver
    int hold_d;
    int hold_id;
    ap_rst    = 1'b1;
    res_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    fill_all();                       // requests during reset must not be taken
    repeat (3) step();
    req_valid = '0;
    ap_rst    = 1'b0;
    step();

    // Single request from requester 2.
    res_ready = 1'b1;
    set_req(2, 3, 1000);
    step();
    drop_accepted();
    @(negedge ap_clk);
    chk("single_valid", int'(res_valid), 1);
    chk("single_data",  int'(res_data),  3000);
    chk("single_id",    int'(res_id),    2);

    // Maximum operands.
    step();
    set_req(0, 255, 65535);
    step();
    drop_accepted();
    @(negedge ap_clk);
    chk("max_data", int'(res_data), 16711425);

    // All requesters continuously valid.
    step();
    for (int n = 0; n < 8; n++) begin
      fill_all();
      step();
      drop_accepted();
    end
    drain_reqs();

    // Backpressure with requester 1 waiting.
    res_ready = 1'b0;
    set_req(1, 17, 4321);
    @(negedge ap_clk);
    hold_d  = int'(res_data);
    hold_id = int'(res_id);
    chk("bp_full", int'(res_valid), 1);
    for (int n = 0; n < 5; n++) begin
      step();
      @(negedge ap_clk);
      chk("bp_hold_data", int'(res_data), hold_d);
      chk("bp_hold_id",   int'(res_id),   hold_id);
    end
    step();
    res_ready = 1'b1;
    step();
    drop_accepted();
    @(negedge ap_clk);
    chk("bp_release_id",   int'(res_id),   1);
    chk("bp_release_data", int'(res_data), 17 * 4321);

    // Randomized traffic.
    step();
    for (int n = 0; n < 400; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 99) < 50)
          set_req(i, $urandom_range(0, 255), $urandom_range(0, 65535));
      step();
      drop_accepted();
    end
    drain_reqs();

    // Reset while a result is held; then all requesters valid.
    fill_all();
    res_ready = 1'b1;
    step();
    drop_accepted();
    ap_rst    = 1'b1;
    res_ready = 1'b0;
    step();
    step();
    ap_rst    = 1'b0;
    res_ready = 1'b1;
    fill_all();
    for (int n = 0; n < 6; n++) begin
      step();
      drop_accepted();
      fill_all();
    end
    drain_reqs();
    repeat (3) step();

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
